ps2_ascii_fifo: RTL and testbench

- Successor to the fixed 8-entry scan-code-to-ASCII converter.
- Consumes PS/2 set-2 bytes from the keyboard receiver and tracks make/break (F0) and extended (E0) prefixes.
- Tracks Shift state and translates make codes to ASCII, including upper-case and shifted symbols.
- Buffers translated characters in a parametrised show-ahead FIFO with an explicit pop handshake, full/overflow status and an occupancy count, for the CPU I/O bus.

---
 rtl/ps2_ascii_fifo.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ps2_ascii_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo
//   Turns PS/2 set-2 scan bytes into ASCII characters and queues them for
//   the CPU I/O bus in a show-ahead FIFO with a pop handshake.
//
//   Decoder: a four-state FSM tracks the break prefix (F0) and the
//   extended prefix (E0). The left/right Shift keys (12/59) are held as
//   level state. Every other make code is translated and pushed.
//   FIFO: DEPTH entries, all of them usable (count tells full from empty).
//   The head entry is held in a register so that ascii is always valid
//   one cycle after the push or pop that changed it.
//
//   Optional build macro PS2_CAPS_LOCK_EN: Caps Lock (58) toggles a caps
//   register that inverts the case of letters, and adds the caps_led port.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   scan_valid in   one-cycle strobe, scan_code holds a new byte
//   scan_code  in   PS/2 set-2 byte
//   rd_en      in   pop the head entry (ignored when empty)
//   ascii      out  head character, 8'h00 when empty
//   fifo_ready out  FIFO non-empty
//   full       out  count == DEPTH
//   overflow   out  sticky, a character was lost to a full FIFO
//   count      out  number of stored entries
//   caps_led   out  caps state (only with PS2_CAPS_LOCK_EN)
module ps2_ascii_fifo #(
  parameter int DEPTH        = 8,
  parameter int AW           = $clog2(DEPTH),
  parameter bit DROP_UNKNOWN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_valid,
  input  logic [7:0]    scan_code,
  input  logic          rd_en,
  output logic [7:0]    ascii,
  output logic          fifo_ready,
  output logic          full,
  output logic          overflow,
`ifdef PS2_CAPS_LOCK_EN
  output logic [AW:0]   count,
  output logic          caps_led
`else
  output logic [AW:0]   count
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  // Returns {mapped, character}. Letters follow shift XOR caps; everything
  // else only follows shift.
  function automatic logic [8:0] xlate(input logic [7:0] code,
                                       input logic shift,
                                       input logic caps);
    logic [7:0] lc;
    logic       letter;
    logic [8:0] res;
    letter = 1'b1;
    lc     = 8'h00;
    res    = 9'h000;
    case (code)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: letter = 1'b0;
    endcase
    if (letter) begin
      res = {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
    end else begin
      case (code)
        8'h16: res = {1'b1, shift ? 8'("!")  : 8'("1")};
        8'h1E: res = {1'b1, shift ? 8'("@")  : 8'("2")};
        8'h26: res = {1'b1, shift ? 8'("#")  : 8'("3")};
        8'h25: res = {1'b1, shift ? 8'("$")  : 8'("4")};
        8'h2E: res = {1'b1, shift ? 8'("%")  : 8'("5")};
        8'h36: res = {1'b1, shift ? 8'("^")  : 8'("6")};
        8'h3D: res = {1'b1, shift ? 8'("&")  : 8'("7")};
        8'h3E: res = {1'b1, shift ? 8'("*")  : 8'("8")};
        8'h46: res = {1'b1, shift ? 8'("(")  : 8'("9")};
        8'h45: res = {1'b1, shift ? 8'(")")  : 8'("0")};
        8'h0E: res = {1'b1, shift ? 8'("~")  : 8'h60};
        8'h4E: res = {1'b1, shift ? 8'("_")  : 8'("-")};
        8'h55: res = {1'b1, shift ? 8'("+")  : 8'("=")};
        8'h54: res = {1'b1, shift ? 8'("{")  : 8'("[")};
        8'h5B: res = {1'b1, shift ? 8'("}")  : 8'("]")};
        8'h5D: res = {1'b1, shift ? 8'("|")  : 8'h5C};
        8'h4C: res = {1'b1, shift ? 8'(":")  : 8'(";")};
        8'h52: res = {1'b1, shift ? 8'h22    : 8'("'")};
        8'h41: res = {1'b1, shift ? 8'("<")  : 8'(",")};
        8'h49: res = {1'b1, shift ? 8'(">")  : 8'(".")};
        8'h4A: res = {1'b1, shift ? 8'("?")  : 8'("/")};
        8'h29: res = 9'h120;
        8'h5A: res = 9'h10D;
        8'h66: res = 9'h108;
        8'h76: res = 9'h11B;
        8'h0D: res = 9'h109;
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- decoder
  state_t state_reg, state_next;
  logic   shift_l_reg, shift_l_next;
  logic   shift_r_reg, shift_r_next;
  logic   caps_cur;
  logic   push_req;
  logic [7:0] push_data;
  logic [8:0] xl;

`ifdef PS2_CAPS_LOCK_EN
  logic caps_reg, caps_next;
  assign caps_cur = caps_reg;
  assign caps_led = caps_reg;
`else
  assign caps_cur = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      shift_l_reg <= 1'b0;
      shift_r_reg <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_l_reg <= shift_l_next;
      shift_r_reg <= shift_r_next;
`ifdef PS2_CAPS_LOCK_EN
      caps_reg    <= caps_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_l_next = shift_l_reg;
    shift_r_next = shift_r_reg;
`ifdef PS2_CAPS_LOCK_EN
    caps_next    = caps_reg;
`endif
    if (scan_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (scan_code == 8'hF0)      state_next   = S_BREAK;
          else if (scan_code == 8'hE0) state_next   = S_EXT;
          else if (scan_code == 8'h12) shift_l_next = 1'b1;
          else if (scan_code == 8'h59) shift_r_next = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
          else if (scan_code == 8'h58) caps_next    = ~caps_reg;
`endif
        end
        S_BREAK: begin
          if (scan_code == 8'h12) shift_l_next = 1'b0;
          if (scan_code == 8'h59) shift_r_next = 1'b0;
          state_next = S_IDLE;
        end
        S_EXT: begin
          if (scan_code == 8'hF0)      state_next = S_EXT_BREAK;
          else if (scan_code == 8'hE0) state_next = S_EXT;
          else                         state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign xl = xlate(scan_code, shift_l_reg | shift_r_reg, caps_cur);

  always_comb begin
    push_req  = 1'b0;
    push_data = 8'h00;
    if (scan_valid) begin
      if (state_reg == S_IDLE) begin
        if (scan_code != 8'hF0 && scan_code != 8'hE0 &&
            scan_code != 8'h12 && scan_code != 8'h59
`ifdef PS2_CAPS_LOCK_EN
            && scan_code != 8'h58
`endif
           ) begin
          if (xl[8]) begin
            push_req  = 1'b1;
            push_data = xl[7:0];
          end else if (!DROP_UNKNOWN) begin
            push_req  = 1'b1;
            push_data = 8'h7F;
          end
        end
      end else if (state_reg == S_EXT && scan_code == 8'h5A) begin
        push_req  = 1'b1;
        push_data = 8'h0D;
      end
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg, rptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [7:0]    head_reg, head_next;
  logic          ovf_reg;
  logic          do_pop, do_push;

  assign do_pop    = rd_en && (count_reg != '0);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push   = push_req && ((count_reg != DEPTH_C) || do_pop);
  assign rptr_next = rptr_reg + AW'(do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push) count_next = count_reg - 1'b1;
  end

  // The head register looks at the entry that will be at the read pointer
  // after this edge. If that slot is being written right now (the FIFO
  // drains to empty and refills in this cycle), take the new data directly.
  always_comb begin
    if (count_next == '0)
      head_next = 8'h00;
    else if (do_push && (wptr_reg == rptr_next))
      head_next = push_data;
    else
      head_next = mem[rptr_next];
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      head_reg  <= 8'h00;
      ovf_reg   <= 1'b0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      head_reg  <= head_next;
      if (push_req && !do_push) ovf_reg <= 1'b1;
    end
  end

  assign ascii      = head_reg;
  assign fifo_ready = (count_reg != '0);
  assign full       = (count_reg == DEPTH_C);
  assign overflow   = ovf_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
module tb_ps2_ascii_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] ascii, ascii2;
  logic       fifo_ready, fifo_ready2, full, full2, overflow, overflow2;
  logic [3:0] count;
  logic [2:0] count2;
`ifdef PS2_CAPS_LOCK_EN
  logic       caps_led, caps_led2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_ascii_fifo #(.DEPTH(8), .DROP_UNKNOWN(1'b1)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .rd_en(rd_en), .ascii(ascii), .fifo_ready(fifo_ready), .full(full),
    .overflow(overflow),
`ifdef PS2_CAPS_LOCK_EN
    .count(count), .caps_led(caps_led)
`else
    .count(count)
`endif
  );

  // Second instance keeps unmapped codes (pushes 7F).
  ps2_ascii_fifo #(.DEPTH(4), .DROP_UNKNOWN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .rd_en(rd_en), .ascii(ascii2), .fifo_ready(fifo_ready2), .full(full2),
    .overflow(overflow2),
`ifdef PS2_CAPS_LOCK_EN
    .count(count2), .caps_led(caps_led2)
`else
    .count(count2)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scan_valid = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code = b; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    $display("tx scan=%02h -> ascii=%02h count=%0d", b, ascii, count);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    $display("tx pop -> ascii=%02h count=%0d", ascii, count);
  endtask

  task automatic push_pop(input logic [7:0] b);
    @(negedge clk);
    scan_code = b; scan_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; rd_en = 1'b0;
    $display("tx scan=%02h+pop -> ascii=%02h count=%0d", b, ascii, count);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 4'd0)      begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (ascii !== 8'h00)     begin n_bad++; $display("FAIL reset_ascii got %02h want 00", ascii); end
    n_cmp++; if (fifo_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", fifo_ready); end
    n_cmp++; if (full !== 1'b0)       begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    // reset after an F0 prefix must return the decoder to IDLE
    send(8'hF0);
    do_reset();
    send(8'h1C);
    n_cmp++; if (count !== 4'd1 || ascii !== 8'h61)
      begin n_bad++; $display("FAIL reset_mid got cnt=%0d ascii=%02h want 1/61", count, ascii); end
  endtask

  task automatic test_break();
    do_reset();
    send(8'h1C);
    n_cmp++; if (fifo_ready !== 1'b1) begin n_bad++; $display("FAIL brk_ready got %b want 1", fifo_ready); end
    n_cmp++; if (ascii !== 8'h61)     begin n_bad++; $display("FAIL brk_ascii got %02h want 61", ascii); end
    send(8'hF0);
    send(8'h1C);
    n_cmp++; if (count !== 4'd1)      begin n_bad++; $display("FAIL brk_count got %0d want 1", count); end
  endtask

  task automatic test_shift();
    do_reset();
    send(8'h12); send(8'h16);
    n_cmp++; if (ascii !== 8'h21) begin n_bad++; $display("FAIL shift_bang got %02h want 21", ascii); end
    send(8'hF0); send(8'h12); send(8'h16);
    n_cmp++; if (count !== 4'd2)  begin n_bad++; $display("FAIL shift_count got %0d want 2", count); end
    pop();
    n_cmp++; if (ascii !== 8'h31) begin n_bad++; $display("FAIL shift_one got %02h want 31", ascii); end
    pop();
    n_cmp++; if (ascii !== 8'h00 || fifo_ready !== 1'b0)
      begin n_bad++; $display("FAIL shift_empty got %02h/%b want 00/0", ascii, fifo_ready); end
    pop(); // pop on empty has no effect
    n_cmp++; if (count !== 4'd0)  begin n_bad++; $display("FAIL pop_empty got %0d want 0", count); end
  endtask

  task automatic test_ext();
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h5A);
    n_cmp++; if (count !== 4'd1 || ascii !== 8'h0D)
      begin n_bad++; $display("FAIL ext_enter got cnt=%0d ascii=%02h want 1/0D", count, ascii); end
    send(8'h1C);
    pop();
    n_cmp++; if (ascii !== 8'h61) begin n_bad++; $display("FAIL ext_idle got %02h want 61", ascii); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    do_reset();
    for (int i = 0; i < 8; i++) send(codes[i]);
    n_cmp++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0)
      begin n_bad++; $display("FAIL ovf_full got f=%b c=%0d o=%b want 1/8/0", full, count, overflow); end
    send(codes[8]);
    n_cmp++; if (overflow !== 1'b1 || count !== 4'd8)
      begin n_bad++; $display("FAIL ovf_set got o=%b c=%0d want 1/8", overflow, count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ascii !== 8'h61 + 8'(i))
        begin n_bad++; $display("FAIL ovf_pop%0d got %02h want %02h", i, ascii, 8'h61 + 8'(i)); end
      pop();
    end
    n_cmp++; if (count !== 4'd0 || overflow !== 1'b1 || full !== 1'b0)
      begin n_bad++; $display("FAIL ovf_end got c=%0d o=%b f=%b want 0/1/0", count, overflow, full); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [8];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    do_reset();
    for (int i = 0; i < 8; i++) send(codes[i]);
    push_pop(8'h3B); // 'j' onto a full FIFO while popping 'a'
    n_cmp++; if (count !== 4'd8 || overflow !== 1'b0 || ascii !== 8'h62)
      begin n_bad++; $display("FAIL b2b_full got c=%0d o=%b a=%02h want 8/0/62", count, overflow, ascii); end
    for (int i = 0; i < 7; i++) pop();
    n_cmp++; if (ascii !== 8'h6A || count !== 4'd1)
      begin n_bad++; $display("FAIL b2b_last got %02h c=%0d want 6A/1", ascii, count); end
    push_pop(8'h1C); // drain last and refill in the same cycle
    n_cmp++; if (ascii !== 8'h61 || count !== 4'd1)
      begin n_bad++; $display("FAIL b2b_one got %02h c=%0d want 61/1", ascii, count); end
    do_reset();
    push_pop(8'h32); // empty: pop ignored, push taken
    n_cmp++; if (ascii !== 8'h62 || count !== 4'd1)
      begin n_bad++; $display("FAIL b2b_empty got %02h c=%0d want 62/1", ascii, count); end
  endtask

  task automatic test_unknown();
    do_reset();
    send(8'h07);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL unk_drop got %0d want 0", count); end
    n_cmp++; if (count2 !== 3'd1 || ascii2 !== 8'h7F)
      begin n_bad++; $display("FAIL unk_keep got c=%0d a=%02h want 1/7F", count2, ascii2); end
`ifndef PS2_CAPS_LOCK_EN
    send(8'h58);
    n_cmp++; if (count !== 4'd0 || count2 !== 3'd2)
      begin n_bad++; $display("FAIL unk_caps got %0d/%0d want 0/2", count, count2); end
`endif
  endtask

  typedef struct { int sh; logic [7:0] code; logic [7:0] exp; } vec_t;
  task automatic test_translate();
    vec_t v [21];
    v = '{'{0, 8'h1C, 8'h61}, '{1, 8'h1C, 8'h41}, '{0, 8'h1A, 8'h7A}, '{1, 8'h1A, 8'h5A},
          '{0, 8'h45, 8'h30}, '{1, 8'h45, 8'h29}, '{1, 8'h1E, 8'h40}, '{0, 8'h0E, 8'h60},
          '{1, 8'h0E, 8'h7E}, '{0, 8'h5D, 8'h5C}, '{1, 8'h5D, 8'h7C}, '{0, 8'h52, 8'h27},
          '{1, 8'h52, 8'h22}, '{1, 8'h4A, 8'h3F}, '{0, 8'h49, 8'h2E}, '{1, 8'h29, 8'h20},
          '{1, 8'h5A, 8'h0D}, '{0, 8'h66, 8'h08}, '{0, 8'h76, 8'h1B}, '{1, 8'h0D, 8'h09},
          '{2, 8'h36, 8'h5E}};
    for (int i = 0; i < 21; i++) begin
      do_reset();
      if (v[i].sh == 1) send(8'h12);
      if (v[i].sh == 2) send(8'h59);
      send(v[i].code);
      n_cmp++; if (count !== 4'd1 || ascii !== v[i].exp)
        begin n_bad++; $display("FAIL xlate_%02h_s%0d got %02h c=%0d want %02h", v[i].code, v[i].sh, ascii, count, v[i].exp); end
    end
    // right shift released by its break code
    send(8'hF0); send(8'h59); send(8'h36);
    pop();
    n_cmp++; if (ascii !== 8'h36) begin n_bad++; $display("FAIL rshift_rel got %02h want 36", ascii); end
  endtask

`ifdef PS2_CAPS_LOCK_EN
  task automatic test_caps();
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    n_cmp++; if (ascii !== 8'h41 || caps_led !== 1'b1 || count !== 4'd1)
      begin n_bad++; $display("FAIL caps_on got %02h led=%b c=%0d want 41/1/1", ascii, caps_led, count); end
    pop();
    send(8'h12); send(8'h1C);
    n_cmp++; if (ascii !== 8'h61) begin n_bad++; $display("FAIL caps_shift got %02h want 61", ascii); end
    send(8'h16);
    pop();
    n_cmp++; if (ascii !== 8'h21) begin n_bad++; $display("FAIL caps_digit got %02h want 21", ascii); end
    do_reset();
    n_cmp++; if (caps_led !== 1'b0) begin n_bad++; $display("FAIL caps_reset got %b want 0", caps_led); end
  endtask
`endif

  initial begin
    test_reset();
    test_break();
    test_shift();
    test_ext();
    test_overflow();
    test_back_to_back();
    test_unknown();
    test_translate();
`ifdef PS2_CAPS_LOCK_EN
    test_caps();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
